// File: rtl/adder_bist_ctrl.sv
// Self-test controller for a WIDTH-bit ripple-carry adder: sweeps every {a,b,cin}
// vector, waits SETTLE_CYCLES, checks {cout,s} against a+b+cin and records results.
module adder_bist_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2*WIDTH:0]     first_fail_vec
);

  localparam int VW  = 2*WIDTH + 1;
  localparam int WCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [VW-1:0]        vec_q, vec_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [VW-1:0]        ffv_q, ffv_d;
  logic                 pass_q, pass_d;

  logic [WIDTH:0]       golden;
  logic                 mism;
  logic                 last_vec;

  // The vector register is the operand drive, so dut_* stay registered and hold
  // the current vector from APPLY through CHECK (and the last one in DONE).
  assign dut_a   = vec_q[VW-1:WIDTH+1];
  assign dut_b   = vec_q[WIDTH:1];
  assign dut_cin = vec_q[0];

  assign golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mism     = golden != {dut_cout, dut_s};
  assign last_vec = &vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_APPLY;
      S_APPLY:        state_d = (SETTLE_CYCLES > 0) ? S_WAIT : S_CHECK;
      S_WAIT:         if (wcnt_q == '0) state_d = S_CHECK;
      S_CHECK:        state_d = last_vec ? S_DONE : S_APPLY;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_APPLY, S_WAIT, S_CHECK: busy = 1'b1;
      S_DONE:                   done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    vec_d  = vec_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    ffv_d  = ffv_q;
    pass_d = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d  = '0;
          err_d  = '0;
          ffv_d  = '0;
          pass_d = 1'b0;
        end
      end
      S_APPLY: wcnt_d = WAIT_LOAD;
      S_WAIT:  wcnt_d = wcnt_q - WCW'(1);
      S_CHECK: begin
        // err_q==0 marks the first mismatch; saturation never brings it back to 0
        if (mism) begin
          if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
          if (err_q == '0) ffv_d = vec_q;
        end
        if (last_vec) pass_d = (err_d == '0);
        else          vec_d  = vec_q + VW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      wcnt_q <= '0;
      err_q  <= '0;
      ffv_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      ffv_q  <= ffv_d;
      pass_q <= pass_d;
    end
  end

  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: behavioural adders with injectable faults, per-sweep
// expectations queued at start and compared when done rises.
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;  // 0 good, 1 cout stuck-0, 2 s[0] stuck-0, 3 all outputs 0
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int err; int ffv; int pas; int cyc;} exp_t;
  exp_t sb[$];

  function automatic logic [4:0] adder(input int m, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0, c};
    case (m)
      1: r[4] = 1'b0;
      2: r[0] = 1'b0;
      3: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  // three instances: default, narrow error counter, zero settle
  logic       st0, st1, st2;
  logic [3:0] a0, b0, s0, a1, b1, s1, a2, b2, s2;
  logic       c0, c1, c2, co0, co1, co2;
  logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [9:0] err0, err2;
  logic [3:0] err1;
  logic [8:0] ffv0, ffv1, ffv2;

  assign {co0, s0} = adder(mode, a0, b0, c0);
  assign {co1, s1} = adder(mode, a1, b1, c1);
  assign {co2, s2} = adder(mode, a2, b2, c2);

  adder_bist_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(st0), .dut_a(a0), .dut_b(b0), .dut_cin(c0),
    .dut_s(s0), .dut_cout(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0));

  adder_bist_ctrl #(.ERR_CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(st1), .dut_a(a1), .dut_b(b1), .dut_cin(c1),
    .dut_s(s1), .dut_cout(co1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1));

  adder_bist_ctrl #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(st2), .dut_a(a2), .dut_b(b2), .dut_cin(c2),
    .dut_s(s2), .dut_cout(co2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ffv2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int errw, input int m, input int cyc);
    exp_t e;
    int   sat;
    e.err = 0; e.ffv = 0; e.cyc = cyc;
    sat = (1 << errw) - 1;
    for (int v = 0; v < 512; v++) begin
      int a, b, c, g;
      logic [4:0] act;
      a = (v >> 5) & 15; b = (v >> 1) & 15; c = v & 1;
      g = a + b + c;
      act = adder(m, 4'(a), 4'(b), 1'(c));
      if (int'(act) != g) begin
        if (e.err == 0) e.ffv = v;
        if (e.err < sat) e.err++;
      end
    end
    e.pas = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  function automatic logic [31:0] g_busy(input int inst);
    case (inst) 0: return 32'(busy0); 1: return 32'(busy1); default: return 32'(busy2); endcase
  endfunction
  function automatic logic [31:0] g_done(input int inst);
    case (inst) 0: return 32'(done0); 1: return 32'(done1); default: return 32'(done2); endcase
  endfunction
  function automatic logic [31:0] g_pass(input int inst);
    case (inst) 0: return 32'(pass0); 1: return 32'(pass1); default: return 32'(pass2); endcase
  endfunction
  function automatic logic [31:0] g_err(input int inst);
    case (inst) 0: return 32'(err0); 1: return 32'(err1); default: return 32'(err2); endcase
  endfunction
  function automatic logic [31:0] g_ffv(input int inst);
    case (inst) 0: return 32'(ffv0); 1: return 32'(ffv1); default: return 32'(ffv2); endcase
  endfunction

  task automatic chk_idle_all(input string tag);
    chk({tag, "_busy"}, {busy0, busy1, busy2}, 0);
    chk({tag, "_done"}, {done0, done1, done2}, 0);
    chk({tag, "_pass"}, {pass0, pass1, pass2}, 0);
    chk({tag, "_err"},  32'(err0) | 32'(err1) | 32'(err2), 0);
    chk({tag, "_ffv"},  32'(ffv0) | 32'(ffv1) | 32'(ffv2), 0);
    chk({tag, "_drv"},  {a0, b0, c0, a1, b1, c1, a2, b2, c2}, 0);
  endtask

  // One sweep on instance inst; optional start re-pulse or reset at cycle n after start.
  task automatic run(input int inst, input int m, input int repulse, input int rst_at);
    int   n;
    bit   fin;
    exp_t e;
    mode = m;
    sb.push_back(model(inst == 1 ? 4 : 10, m, inst == 2 ? 1024 : 2048));
    @(negedge clk); set_start(inst, 1'b1);
    @(posedge clk); #1; set_start(inst, 1'b0);
    chk("busy_rise", g_busy(inst), 1);
    chk("pass_while_busy", g_pass(inst), 0);
    n = 0; fin = 0;
    while (!fin && n < 5000) begin
      @(posedge clk); n++; #1;
      set_start(inst, (n == repulse) ? 1'b1 : 1'b0);
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_idle_all("async_rst");
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk_idle_all("post_rst_idle");
        return;
      end
      if (g_done(inst) == 1) fin = 1;
    end
    if (!fin) chk("done_timeout", 0, 1);
    e = sb.pop_front();
    chk("done_cycles", n, e.cyc);
    chk("busy_at_done", g_busy(inst), 0);
    chk("pass", g_pass(inst), e.pas);
    chk("err_count", g_err(inst), e.err);
    chk("first_fail_vec", g_ffv(inst), e.ffv);
    if (inst == 0) chk("drive_holds_last", {a0, b0, c0}, 9'h1FF);
    repeat (3) @(posedge clk);
    #1 chk("done_held", g_done(inst), 1);
  endtask

  initial begin
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    #23 chk_idle_all("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle_all("idle_after_rst");

    run(0, 0, -1, -1);   // clean sweep
    run(0, 1, -1, -1);   // cout stuck-at-0
    run(0, 2, -1, -1);   // s[0] stuck-at-0
    run(0, 0, 500, -1);  // start re-pulse while busy is ignored
    run(0, 1, -1, 700);  // reset mid-sweep
    run(0, 0, -1, -1);   // clean sweep after reset
    run(1, 3, -1, -1);   // saturating counter
    run(2, 0, -1, -1);   // zero settle

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
